// File: rtl/ex_store_buffer.sv
// Write-posting store buffer between EX and the AHB3-Lite data bus.
// Queues stores in order, retires them one beat at a time, flags load hazards.
module ex_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          s_clk_i,
  input  logic          s_reset_i,
  input  logic          s_st_valid_i,
  input  logic [31:0]   s_st_addr_i,
  input  logic [31:0]   s_st_data_i,
  input  logic [1:0]    s_st_size_i,
  output logic          s_st_ready_o,
  input  logic [31:0]   s_ld_addr_i,
  output logic          s_ld_hazard_o,
  output logic          s_empty_o,
  output logic [CW-1:0] s_count_o,
  output logic [31:0]   s_haddr_o,
  output logic [1:0]    s_htrans_o,
  output logic          s_hwrite_o,
  output logic [2:0]    s_hsize_o,
  output logic [31:0]   s_hwdata_o,
  input  logic          s_hready_i,
  input  logic          s_hresp_i,
  output logic          s_err_o,
  output logic [31:0]   s_err_addr_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t          state_q;
  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [1:0]      size_q [DEPTH];
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_nx;
  logic            push;
  logic            pop;
  logic            err_q;
  logic [31:0]     err_addr_q;
  logic            hazard;
  logic [PW-1:0]   idx;
  logic            unused_ld_lsb;

  assign s_st_ready_o = (count_q != CW'(DEPTH));
  assign push         = s_st_valid_i & s_st_ready_o;
  assign pop          = (state_q == S_DATA) & s_hready_i;
  assign count_nx     = count_q + CW'(push) - CW'(pop);

  // Entry storage: written at the tail on every accepted store
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wptr_q] <= s_st_addr_i;
      data_q[wptr_q] <= s_st_data_i;
      size_q[wptr_q] <= s_st_size_i;
    end
  end

  // Circular pointers and occupancy
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_nx;
    end
  end

  // Bus FSM: address phase then data phase per head entry
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (count_nx != '0) state_q <= S_ADDR;
        S_ADDR: if (s_hready_i) state_q <= S_DATA;
        S_DATA: begin
          if (s_hready_i)
            state_q <= (count_nx != '0) ? S_ADDR : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Error pulse and sticky address of the last failed store
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= pop & s_hresp_i;
      if (pop & s_hresp_i) err_addr_q <= addr_q[rptr_q];
    end
  end

  // Word-granular match of the load against every queued store
  always_comb begin
    hazard = 1'b0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q + PW'(k);
      if ((CW'(k) < count_q) &&
          (addr_q[idx][31:2] == s_ld_addr_i[31:2]))
        hazard = 1'b1;
    end
  end

  assign unused_ld_lsb = ^s_ld_addr_i[1:0];

  assign s_ld_hazard_o = hazard;
  assign s_empty_o     = (count_q == '0) & (state_q == S_IDLE);
  assign s_count_o     = count_q;
  assign s_haddr_o     = addr_q[rptr_q];
  assign s_hsize_o     = {1'b0, size_q[rptr_q]};
  assign s_hwdata_o    = data_q[rptr_q];
  assign s_htrans_o    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign s_hwrite_o    = (state_q == S_ADDR);
  assign s_err_o       = err_q;
  assign s_err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_ex_store_buffer.sv
// Bench for ex_store_buffer: directed scenarios plus random traffic,
// all checked every cycle against a queue-based bus model.
module tb_ex_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_size;
  logic          st_ready;
  logic [31:0]   ld_addr;
  logic          ld_hazard;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [31:0]   hwdata;
  logic          hready;
  logic          hresp;
  logic          err;
  logic [31:0]   err_addr;

  ex_store_buffer #(.DEPTH(DEPTH)) dut (
    .s_clk_i      (clk),
    .s_reset_i    (rst),
    .s_st_valid_i (st_valid),
    .s_st_addr_i  (st_addr),
    .s_st_data_i  (st_data),
    .s_st_size_i  (st_size),
    .s_st_ready_o (st_ready),
    .s_ld_addr_i  (ld_addr),
    .s_ld_hazard_o(ld_hazard),
    .s_empty_o    (empty),
    .s_count_o    (count),
    .s_haddr_o    (haddr),
    .s_htrans_o   (htrans),
    .s_hwrite_o   (hwrite),
    .s_hsize_o    (hsize),
    .s_hwdata_o   (hwdata),
    .s_hready_i   (hready),
    .s_hresp_i    (hresp),
    .s_err_o      (err),
    .s_err_addr_o (err_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst) assert (!(st_valid && st_size == 2'd3));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  // model: pending stores in order, plus which bus phase the head is in
  st_t         q[$];
  int          phase;
  logic        m_err;
  logic [31:0] m_err_addr;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    phase      = 0;
    m_err      = 1'b0;
    m_err_addr = '0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready",   32'(st_ready),  32'd1);
    chk("rst_empty",   32'(empty),     32'd1);
    chk("rst_count",   32'(count),     32'd0);
    chk("rst_hazard",  32'(ld_hazard), 32'd0);
    chk("rst_htrans",  32'(htrans),    32'd0);
    chk("rst_hwrite",  32'(hwrite),    32'd0);
    chk("rst_haddr",   haddr,          32'd0);
    chk("rst_hsize",   32'(hsize),     32'd0);
    chk("rst_hwdata",  hwdata,         32'd0);
    chk("rst_err",     32'(err),       32'd0);
    chk("rst_erraddr", err_addr,       32'd0);
  endtask

  task automatic chk_outputs();
    logic hz;
    hz = 1'b0;
    foreach (q[i])
      if (q[i].addr[31:2] == ld_addr[31:2]) hz = 1'b1;
    chk("count",   32'(count),     32'(q.size()));
    chk("ready",   32'(st_ready),  32'(q.size() != DEPTH));
    chk("empty",   32'(empty),     32'(q.size() == 0 && phase == 0));
    chk("hazard",  32'(ld_hazard), 32'(hz));
    chk("htrans",  32'(htrans),    (phase == 1) ? 32'd2 : 32'd0);
    chk("hwrite",  32'(hwrite),    32'(phase == 1));
    if (phase == 1) begin
      chk("haddr", haddr,       q[0].addr);
      chk("hsize", 32'(hsize),  32'(q[0].size));
    end
    if (phase == 2) chk("hwdata", hwdata, q[0].data);
    chk("err",     32'(err),       32'(m_err));
    chk("errаddr", err_addr,       m_err_addr);
  endtask

  task automatic step(input bit v, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] sz,
                      input logic [31:0] ld, input bit hr, input bit he);
    bit pu;
    bit po;
    st_t e;
    @(negedge clk);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
    ld_addr  = ld;
    hready   = hr;
    hresp    = he;
    #1;
    chk_outputs();
    pu = v && (q.size() != DEPTH);
    po = (phase == 2) && hr;
    m_err = po && he;
    if (m_err) m_err_addr = q[0].addr;
    if (po) void'(q.pop_front());
    if (pu) begin
      e.addr = a;
      e.data = d;
      e.size = sz;
      q.push_back(e);
    end
    case (phase)
      0: if (q.size() > 0) phase = 1;
      1: if (hr) phase = 2;
      default: if (hr) phase = (q.size() > 0) ? 1 : 0;
    endcase
  endtask

  task automatic idle(input int n, input bit hr);
    for (int i = 0; i < n; i++) step(0, '0, '0, 2'd0, '0, hr, 0);
  endtask

  function automatic logic [31:0] raddr();
    return 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    rst      = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_size  = '0;
    ld_addr  = '0;
    hready   = 1'b1;
    hresp    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk_reset_vals();
    rst = 1'b0;

    // single store, zero wait states
    step(1, 32'h1000_0004, 32'hDEAD_BEEF, 2'd2, '0, 1, 0);
    idle(4, 1);

    // fill with bus stalled, then overflow attempt
    for (int i = 0; i < 5; i++)
      step(1, raddr(), $urandom, 2'($urandom_range(0, 2)), '0, 0, 0);
    idle(10, 1);
    for (int i = 0; i < 6; i++)
      step(1, raddr(), $urandom, 2'($urandom_range(0, 2)), '0, 0, 0);
    idle(12, 1);

    // wait states in address then data phase
    step(1, 32'h1000_0040, 32'h1234_5678, 2'd1, '0, 0, 0);
    idle(3, 0);
    idle(1, 1);
    idle(2, 0);
    idle(3, 1);

    // load hazard against a queued store
    step(1, 32'h2000_0008, 32'h0, 2'd2, '0, 0, 0);
    step(0, '0, '0, 2'd0, 32'h2000_000A, 0, 0);
    step(0, '0, '0, 2'd0, 32'h2000_000C, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, '0, '0, 2'd0, 32'h2000_0008, 1, 0);

    // error on second store, third still retires
    step(1, 32'h3000_0000, 32'h1, 2'd2, '0, 0, 0);
    step(1, 32'h3000_0004, 32'h2, 2'd2, '0, 0, 0);
    step(1, 32'h3000_0008, 32'h3, 2'd2, '0, 0, 0);
    idle(3, 1);
    step(0, '0, '0, 2'd0, '0, 0, 1);
    step(0, '0, '0, 2'd0, '0, 1, 1);
    idle(5, 1);

    // random traffic with varying bus stall rates
    for (int seg = 0; seg < 8; seg++) begin
      int stall;
      stall = $urandom_range(0, 3);
      for (int i = 0; i < 200; i++) begin
        logic [31:0] ld;
        ld = raddr();
        if (q.size() > 0 && $urandom_range(0, 1) == 1)
          ld = q[$urandom_range(0, q.size() - 1)].addr
               | 32'($urandom_range(0, 3));
        step($urandom_range(0, 1) == 1, raddr(), $urandom,
             2'($urandom_range(0, 2)), ld,
             $urandom_range(0, 3) >= stall,
             $urandom_range(0, 7) == 0);
      end
    end
    idle(12, 1);

    // reset during a data phase with entries queued
    for (int i = 0; i < 3; i++)
      step(1, raddr(), $urandom, 2'd2, '0, 0, 0);
    step(0, '0, '0, 2'd0, '0, 1, 0);
    step(0, '0, '0, 2'd0, '0, 0, 0);
    chk("pre_rst_phase", 32'(phase), 32'd2);
    @(negedge clk);
    st_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(6, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_store_buffer.md
# ex_store_buffer

Parametrised write-posting buffer between the Execute stage and the data bus. It accepts store instructions from EX in a single cycle, queues up to DEPTH of them, and retires them to the AHB3-Lite data bus in order. This removes the EX stall that a store currently causes while `hready` is low. Loads are checked against every queued store so that a younger load never passes an older store to the same word.

## Interface
Parameters:
- DEPTH, 4, number of store entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override)

Ports:
- s_clk_i  in  1  clock
- s_reset_i  in  1  reset; asynchronous, active-high
- s_st_valid_i  in  1  store request from EX; only accepted while s_st_ready_o=1
- s_st_addr_i  in  32  store address; already aligned by EX
- s_st_data_i  in  32  store data, already byte-lane aligned
- s_st_size_i  in  2  0=byte, 1=half, 2=word; 3 is illegal
- s_st_ready_o  out  1  buffer can accept a store this cycle
- s_ld_addr_i  in  32  address of the load currently in EX
- s_ld_hazard_o  out  1  a queued store matches s_ld_addr_i[31:2]
- s_empty_o  out  1  no queued stores and no bus transfer in progress (used by fence/drain)
- s_count_o  out  CW  number of valid entries
- s_haddr_o  out  32  AHB address
- s_htrans_o  out  2  AHB transfer type; only IDLE (2'b00) or NONSEQ (2'b10)
- s_hwrite_o  out  1  AHB write; 1 whenever htrans=NONSEQ, otherwise 0
- s_hsize_o  out  3  {1'b0, entry size}
- s_hwdata_o  out  32  AHB write data
- s_hready_i  in  1  AHB ready
- s_hresp_i  in  1  AHB error response
- s_err_o  out  1  one-cycle pulse: a posted store was answered with an error
- s_err_addr_o  out  32  address of the last store that received an error

## Operation
- Storage is a circular FIFO with a write pointer, a read pointer and a count.
  - Push = s_st_valid_i & s_st_ready_o.
  - Pop = completion of the head entry's data phase.
  - Push and pop in the same cycle leave the count unchanged. Both pointers wrap modulo DEPTH.
- s_st_ready_o = (count != DEPTH). It depends only on registered state, never on s_hready_i. A pop in the current cycle does not raise ready until the next cycle.
- Bus FSM states are IDLE, ADDR and DATA.
  - IDLE: htrans=IDLE. Go to ADDR when count>0 at the start of the cycle.
  - ADDR: htrans=NONSEQ, hwrite=1, haddr and hsize taken from the head entry. Once NONSEQ is presented, it and the head address and size stay stable until s_hready_i=1, and the transfer is never withdrawn. On hready=1, go to DATA.
  - DATA: htrans=IDLE, hwdata=head data, held stable. On hready=1:
    - pop the head entry;
    - if s_hresp_i=1, set err and capture the head address;
    - go to ADDR if count-after-pop>0, otherwise IDLE.
- Error handling: the entry is dropped, not retried. s_err_o is a registered pulse in the cycle after the completing error beat. s_err_addr_o holds its value until the next error. The first error cycle (hresp=1, hready=0) has no effect.
- s_ld_hazard_o is combinational. It is the OR over all valid entries, including the head during ADDR and DATA, of (entry_addr[31:2] == s_ld_addr_i[31:2]). A store pushed in the same cycle is not compared.
- s_hwdata_o is don't-care outside DATA and is driven with the head data.
- s_empty_o = (count==0) & (state==IDLE).
- An illegal size (3) is stored as-is. EX never issues it, and the bench checks this with an assertion.

## Timing
- Reset values: FSM=IDLE, pointers=0, count=0, s_st_ready_o=1, s_empty_o=1, s_ld_hazard_o=0, s_htrans_o=IDLE, s_hwrite_o=0, s_err_o=0, s_err_addr_o=0, s_haddr_o=0, s_hsize_o=0, s_hwdata_o=0.
- A reset asserted mid-transfer abandons the transfer immediately and discards all entries.
- Push in cycle N: count and hazard update in N+1; NONSEQ appears in N+1 if the FSM was IDLE.
- With zero wait states: ADDR at N+1, DATA at N+2, pop at the end of N+2, count=0 and s_empty_o=1 in N+3.
- Sustained throughput is one store per 2 cycles. Each wait state adds one cycle to the ADDR or DATA state it occurs in.
- Full buffer: a push attempt with ready=0 is ignored, and the buffer contents and count are unchanged.

## Test plan
- Single store: push addr 0x1000_0004, data 0xDEADBEEF, size 2, hready=1 -> htrans=NONSEQ in N+1 with haddr 0x1000_0004 and hsize 3'b010; hwdata 0xDEADBEEF in N+2; s_empty_o=1 in N+3.
- Fill and wrap: DEPTH=4, hready=0, push 5 stores -> ready=0 after the 4th and the 5th is ignored. Release hready -> the 4 stores retire in push order; then push 6 more -> pointers wrap and order is preserved.
- Wait states: hready low 3 cycles in ADDR -> haddr and htrans stay stable and NONSEQ is never dropped; hready low 2 cycles in DATA -> hwdata stays stable and the pop is delayed by 2.
- Hazard: queue a store to 0x2000_0008 -> load addr 0x2000_000A gives hazard=1; load addr 0x2000_000C gives 0; hazard clears in the cycle after the pop.
- Error: second store receives hresp=1/hready=0 then hresp=1/hready=1 -> s_err_o pulses one cycle later, s_err_addr_o = that store's address, and the third store still retires.
- Reset mid-DATA with 3 entries queued -> all outputs return to their reset values asynchronously; no further NONSEQ is issued after reset is released.
